// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller: CPU stores go into a byte FIFO that a
// small sequencer drains into the transmitter over its write_en/data/busy handshake.
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        tx_write_en,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [CNT_W-1:0]   r_count;
    logic               r_enable;
    logic               r_irqEn;
    logic               r_overflow;
    logic               r_irq;

    logic               w_full;
    logic               w_empty;
    logic               w_active;
    logic               w_txWrite;
    logic               w_push;
    logic               w_overflow;
    logic               w_pop;
    logic               w_statusWrite;
    logic               w_ctrlWrite;
    logic               w_flush;
    logic [31:0]        w_status;
    logic               w_unused;

    assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_active      = (r_state != IDLE) || tx_busy;

    // Fullness is judged on the pre-edge count, so a push while full is lost even if LOAD pops.
    assign w_txWrite     = bus_we && (bus_addr == 4'h0);
    assign w_push        = w_txWrite && !w_full;
    assign w_overflow    = w_txWrite && w_full;
    assign w_pop         = (r_state == LOAD);
    assign w_statusWrite = bus_we && (bus_addr == 4'h4);
    assign w_ctrlWrite   = bus_we && (bus_addr == 4'h8);
    assign w_flush       = w_ctrlWrite && bus_wdata[1];

    assign w_unused      = &{1'b0, bus_wdata[31:8]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= bus_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable   <= 1'b1;
            r_irqEn    <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_ctrlWrite) begin
                r_enable <= bus_wdata[0];
                r_irqEn  <= bus_wdata[2];
            end
            // A fresh overflow beats a simultaneous software clear.
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end else if (w_statusWrite && bus_wdata[3]) begin
                r_overflow <= 1'b0;
            end
            r_irq <= r_irqEn && w_empty && (r_state == IDLE) && !tx_busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:       if (r_enable && !w_empty && !tx_busy) w_nextState = LOAD;
            LOAD:       w_nextState = WAIT_START;
            WAIT_START: if (tx_busy) w_nextState = WAIT_DONE;
            WAIT_DONE:  if (!tx_busy) w_nextState = IDLE;
            default:    w_nextState = IDLE;
        endcase
    end

    assign tx_write_en = (r_state == LOAD);
    assign tx_data     = (r_state == LOAD) ? r_mem[r_rdPtr] : 8'h00;
    assign irq         = r_irq;

    always_comb begin
        w_status                = '0;
        w_status[0]             = w_full;
        w_status[1]             = w_empty;
        w_status[2]             = w_active;
        w_status[3]             = r_overflow;
        w_status[8 +: CNT_W]    = r_count;

        bus_rdata = '0;
        if (bus_re) begin
            case (bus_addr)
                4'h4:    bus_rdata = w_status;
                4'h8:    bus_rdata = {29'b0, r_irqEn, 1'b0, r_enable};
                default: bus_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a 10-bit-frame transmitter model
// (1 MHz clock, 100 kbaud -> 100 cycles of busy per byte).
module tb_uart_tx_ctrl;

    localparam int FRAME_CYCLES = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_we;
    logic        bus_re;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        tx_write_en;
    logic [7:0]  tx_data;
    logic        txBusy;
    logic        irq;

    int          vecCount = 0;
    int          missCount = 0;
    int          pulseWhileBusy = 0;
    int          activeEarly = 0;
    int          frameCnt;
    logic [7:0]  txLog [$];
    logic [31:0] rd;

    uart_tx_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .tx_write_en (tx_write_en),
        .tx_data     (tx_data),
        .tx_busy     (txBusy),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // Transmitter model: registers busy on the load edge and holds it for one frame.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            txBusy   <= 1'b0;
            frameCnt <= 0;
        end else if (tx_write_en) begin
            if (txBusy) pulseWhileBusy++;
            txLog.push_back(tx_data);
            txBusy   <= 1'b1;
            frameCnt <= FRAME_CYCLES - 1;
        end else if (txBusy) begin
            if (frameCnt == 0) txBusy <= 1'b0;
            else frameCnt <= frameCnt - 1;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_we    = 1'b1;
        bus_addr  = addr;
        bus_wdata = data;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus_re   = 1'b1;
        bus_addr = addr;
        #1 data  = bus_rdata;
        bus_re   = 1'b0;
    endtask

    task automatic waitDrained(input int expLen, input int budget);
        logic [31:0] st;
        bit          done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            bus_re   = 1'b1;
            bus_addr = 4'h4;
            #1 st    = bus_rdata;
            if (txBusy && !st[2]) activeEarly++;
            if (txLog.size() == expLen && !txBusy && !st[2] && st[1]) done = 1'b1;
        end
        bus_re = 1'b0;
        checkOutput("drainDone", {31'b0, done}, 32'h1);
    endtask

    task automatic waitBusy(input logic level, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (txBusy == level) seen = 1'b1;
        end
        checkOutput("busyWait", {31'b0, seen}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        readReg(4'h4, rd);  checkOutput("rstStatus", rd, 32'h0000_0002);
        readReg(4'h8, rd);  checkOutput("rstCtrl", rd, 32'h1);
        readReg(4'h0, rd);  checkOutput("txdataRead", rd, 32'h0);
        readReg(4'hC, rd);  checkOutput("badAddrRead", rd, 32'h0);
        checkOutput("rstWriteEn", {31'b0, tx_write_en}, 32'h0);
        checkOutput("rstTxData", {24'b0, tx_data}, 32'h0);
        checkOutput("rstIrq", {31'b0, irq}, 32'h0);

        // Three bytes straight through.
        applyStimulus(4'h0, 32'h41);
        applyStimulus(4'h0, 32'h42);
        applyStimulus(4'h0, 32'h43);
        waitDrained(3, 1000);
        checkOutput("log3Size", txLog.size(), 32'd3);
        checkOutput("log3Byte0", {24'b0, txLog[0]}, 32'h41);
        checkOutput("log3Byte1", {24'b0, txLog[1]}, 32'h42);
        checkOutput("log3Byte2", {24'b0, txLog[2]}, 32'h43);

        // Disabled fill past full, clear overflow, then release.
        applyStimulus(4'h8, 32'h0);
        for (int i = 0; i < 17; i++) applyStimulus(4'h0, i);
        readReg(4'h4, rd);  checkOutput("fullOvfStatus", rd, 32'h0000_1009);
        checkOutput("noTxDisabled", txLog.size(), 32'd3);
        applyStimulus(4'h4, 32'h8);
        readReg(4'h4, rd);  checkOutput("ovfCleared", rd, 32'h0000_1001);
        applyStimulus(4'h8, 32'h1);
        waitDrained(19, 3000);
        checkOutput("log16Size", txLog.size(), 32'd19);
        for (int i = 0; i < 16; i++) checkOutput("log16Byte", {24'b0, txLog[3 + i]}, i);

        // Push collides with the LOAD pop while full.
        applyStimulus(4'h8, 32'h0);
        for (int i = 0; i < 16; i++) applyStimulus(4'h0, 32'h80 + i);
        readReg(4'h4, rd);  checkOutput("refullStatus", rd, 32'h0000_1001);
        applyStimulus(4'h8, 32'h1);
        applyStimulus(4'h0, 32'hEE);
        readReg(4'h4, rd);  checkOutput("pushPopFull", rd, 32'h0000_0F0C);
        waitDrained(35, 3000);
        checkOutput("logFullSize", txLog.size(), 32'd35);
        for (int i = 0; i < 16; i++) checkOutput("logFullByte", {24'b0, txLog[19 + i]}, 32'h80 + i);
        applyStimulus(4'h4, 32'h8);
        readReg(4'h4, rd);  checkOutput("ovfClear2", rd, 32'h0000_0002);

        // Flush during the first frame.
        applyStimulus(4'h0, 32'hA0);
        applyStimulus(4'h0, 32'hA1);
        applyStimulus(4'h0, 32'hA2);
        applyStimulus(4'h0, 32'hA3);
        applyStimulus(4'h8, 32'h3);
        readReg(4'h4, rd);  checkOutput("flushStatus", rd, 32'h0000_0006);
        readReg(4'h8, rd);  checkOutput("flushCtrlRead", rd, 32'h1);
        waitDrained(36, 1000);
        checkOutput("flushLogSize", txLog.size(), 32'd36);
        checkOutput("flushLogByte", {24'b0, txLog[35]}, 32'hA0);

        // Drained interrupt around a single frame.
        applyStimulus(4'h8, 32'h5);
        readReg(4'h8, rd);  checkOutput("ctrlIrqEn", rd, 32'h5);
        checkOutput("irqIdle", {31'b0, irq}, 32'h1);
        applyStimulus(4'h0, 32'h77);
        waitBusy(1'b1, 20);
        checkOutput("irqFrame", {31'b0, irq}, 32'h0);
        waitBusy(1'b0, 200);
        checkOutput("irqBusyFall", {31'b0, irq}, 32'h0);
        @(negedge clk);
        checkOutput("irqCondCycle", {31'b0, irq}, 32'h0);
        @(negedge clk);
        checkOutput("irqRise", {31'b0, irq}, 32'h1);
        checkOutput("irqLogByte", {24'b0, txLog[36]}, 32'h77);

        // Reset mid-frame.
        applyStimulus(4'h0, 32'h55);
        applyStimulus(4'h0, 32'h66);
        waitBusy(1'b1, 20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rstMidIrq", {31'b0, irq}, 32'h0);
        checkOutput("rstMidWriteEn", {31'b0, tx_write_en}, 32'h0);
        readReg(4'h4, rd);  checkOutput("rstMidStatus", rd, 32'h0000_0002);
        @(negedge clk);
        rst = 1'b0;
        readReg(4'h8, rd);  checkOutput("rstMidCtrl", rd, 32'h1);
        repeat (300) @(negedge clk);
        checkOutput("rstMidLogSize", txLog.size(), 32'd38);
        checkOutput("rstMidLogByte", {24'b0, txLog[37]}, 32'h55);
        checkOutput("postRstIrq", {31'b0, irq}, 32'h0);

        checkOutput("pulseWhileBusy", pulseWhileBusy, 32'd0);
        checkOutput("activeEarly", activeEarly, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
